// File: rtl/jt12_mix_pkg.sv
// Shared types and constants for the Megadrive output-mixer clock-enable scheduler.
// Divider moduli and strobe phases live here so the top and its dividers agree.
package jt12_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int DIV_9   = 9;
  localparam int DIV_63  = 63;
  localparam int DIV_252 = 252;
  localparam int DIV_48  = 48;
  localparam int DIV_144 = 144;
  localparam int DIV_5   = 5;

  localparam int PH_FM  = 8;
  localparam int PH_PSG = 47;

  localparam logic [7:0] SLIP_MAX = 8'hFF;

  // A clear coinciding with a new slip leaves that slip counted.
  function automatic logic [7:0] slip_next(input logic [7:0] cnt, input logic clr);
    if (clr)
      return 8'd1;
    else if (cnt == SLIP_MAX)
      return cnt;
    else
      return cnt + 8'd1;
  endfunction

endpackage

// File: rtl/jt12_mixsched_div.sv
// Mod-N counter with clear/enable and a registered strobe on count == PHASE.
// The strobe reflects the count as seen before any clear in the same cycle.
module jt12_mixsched_div #(
  parameter int N     = 9,
  parameter int PHASE = N - 1,
  parameter int W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         strb
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] PH   = W'(PHASE);

  logic [W-1:0] cnt_reg;
  logic         strb_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      strb_reg <= 1'b0;
    end else begin
      strb_reg <= en && (cnt_reg == PH);
      if (clr)
        cnt_reg <= '0;
      else if (en)
        cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign strb = strb_reg;

endmodule

// File: rtl/jt12_mixsched.sv
// Mixer clock-enable scheduler: one frame counter phase-locked to the FM sample
// pulse, feeding FM/PSG rate strobes plus lock and slip reporting.
module jt12_mixsched
  import jt12_mix_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int FRAME  = 1008
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fm_sample,
  input  logic       slip_clr,
  output logic       cen_9,
  output logic       cen_63,
  output logic       cen_252,
  output logic       cen_1008,
  output logic       psg_cen_48,
  output logic       psg_cen_144,
  output logic       psg_cen_240,
  output logic       psg_cen_1008,
  output logic       locked,
  output logic [7:0] slip_cnt
);

  localparam int             PW       = $clog2(FRAME);
  localparam logic [PW-1:0]  P_LAST   = PW'(FRAME - 1);
  localparam logic [PW-1:0]  P_FM     = PW'(PH_FM);
  localparam logic [PW-1:0]  P_PSG    = PW'(PH_PSG);
  localparam logic [3:0]     GOOD_MAX = 4'(LOCK_N);

  state_t        state_reg;
  logic [PW-1:0] p_reg;
  logic [3:0]    good_reg;
  logic          locked_reg;
  logic [7:0]    slip_reg;
  logic          cen_1008_reg;
  logic          psg_1008_reg;

  logic run_en, at_end, good, early, missing, slip, frame_clr;
  logic [5:0] cnt48;
  logic [3:0] unused_cnt9;
  logic [5:0] unused_cnt63;
  logic [7:0] unused_cnt252;
  logic [7:0] unused_cnt144;
  logic [2:0] unused_psg5;

  // A disabled cycle is treated as leaving RUN, so fm_sample is ignored there.
  assign run_en    = (state_reg == ST_RUN) && enable;
  assign at_end    = (p_reg == P_LAST);
  assign good      = run_en && fm_sample && at_end;
  assign early     = run_en && fm_sample && !at_end;
  assign missing   = run_en && !fm_sample && at_end;
  assign slip      = early || missing;
  assign frame_clr = !run_en || early;

  jt12_mixsched_div #(.N(DIV_9),   .PHASE(PH_FM))  u_div9 (
    .clk(clk), .rst(rst), .clr(frame_clr), .en(run_en), .cnt(unused_cnt9),   .strb(cen_9));
  jt12_mixsched_div #(.N(DIV_63),  .PHASE(PH_FM))  u_div63 (
    .clk(clk), .rst(rst), .clr(frame_clr), .en(run_en), .cnt(unused_cnt63),  .strb(cen_63));
  jt12_mixsched_div #(.N(DIV_252), .PHASE(PH_FM))  u_div252 (
    .clk(clk), .rst(rst), .clr(frame_clr), .en(run_en), .cnt(unused_cnt252), .strb(cen_252));
  jt12_mixsched_div #(.N(DIV_48),  .PHASE(PH_PSG)) u_div48 (
    .clk(clk), .rst(rst), .clr(frame_clr), .en(run_en), .cnt(cnt48),         .strb(psg_cen_48));
  jt12_mixsched_div #(.N(DIV_144), .PHASE(PH_PSG)) u_div144 (
    .clk(clk), .rst(rst), .clr(frame_clr), .en(run_en), .cnt(unused_cnt144), .strb(psg_cen_144));

  // psg5 survives frame resyncs; 240 does not divide the frame, so it free-runs.
  jt12_mixsched_div #(.N(DIV_5), .PHASE(0)) u_psg5 (
    .clk(clk), .rst(rst),
    .clr(state_reg != ST_RUN),
    .en(run_en && (cnt48 == 6'(PH_PSG))),
    .cnt(unused_psg5), .strb(psg_cen_240));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      p_reg        <= '0;
      good_reg     <= '0;
      locked_reg   <= 1'b0;
      slip_reg     <= '0;
      cen_1008_reg <= 1'b0;
      psg_1008_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (enable) state_reg <= ST_SEEK;
        ST_SEEK: begin
          if (!enable)        state_reg <= ST_IDLE;
          else if (fm_sample) state_reg <= ST_RUN;
        end
        ST_RUN:  if (!enable) state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase

      if (frame_clr)
        p_reg <= '0;
      else
        p_reg <= at_end ? '0 : p_reg + 1'b1;

      cen_1008_reg <= run_en && (p_reg == P_FM);
      psg_1008_reg <= run_en && (p_reg == P_PSG);

      if (!run_en || slip) begin
        good_reg   <= '0;
        locked_reg <= 1'b0;
      end else if (good) begin
        if (good_reg != GOOD_MAX) good_reg <= good_reg + 4'd1;
        if (good_reg >= GOOD_MAX - 4'd1) locked_reg <= 1'b1;
      end

      if (slip)
        slip_reg <= slip_next(slip_reg, slip_clr);
      else if (slip_clr)
        slip_reg <= '0;
    end
  end

  assign cen_1008     = cen_1008_reg;
  assign psg_cen_1008 = psg_1008_reg;
  assign locked       = locked_reg;
  assign slip_cnt     = slip_reg;

endmodule

// File: tb/tb_jt12_mixsched.sv
// Directed bench for jt12_mixsched: lock acquisition, slips, saturation,
// enable drop and asynchronous reset, with hand-computed cycle expectations.
module tb_jt12_mixsched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       fm_sample = 1'b0;
  logic       slip_clr = 1'b0;
  logic       cen_9, cen_63, cen_252, cen_1008;
  logic       psg_cen_48, psg_cen_144, psg_cen_240, psg_cen_1008;
  logic       locked;
  logic [7:0] slip_cnt;

  wire [7:0] strobes = {cen_9, cen_63, cen_252, cen_1008,
                        psg_cen_48, psg_cen_144, psg_cen_240, psg_cen_1008};

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, fm_next = -1;
  int last_1008 = -1, per_1008 = 0;
  int n9 = 0, n48 = 0, n_any = 0;
  bit fm_force = 1'b0;

  always #5 clk = ~clk;

  jt12_mixsched dut (
    .clk(clk), .rst(rst), .enable(enable), .fm_sample(fm_sample), .slip_clr(slip_clr),
    .cen_9(cen_9), .cen_63(cen_63), .cen_252(cen_252), .cen_1008(cen_1008),
    .psg_cen_48(psg_cen_48), .psg_cen_144(psg_cen_144), .psg_cen_240(psg_cen_240),
    .psg_cen_1008(psg_cen_1008), .locked(locked), .slip_cnt(slip_cnt)
  );

  // One clock: drive fm_sample for this cycle, then observe the next one.
  task automatic tick();
    fm_sample = fm_force || (cyc == fm_next);
    @(posedge clk);
    #1;
    if (!fm_force && fm_next >= 0 && cyc == fm_next) fm_next += 1008;
    fm_sample = 1'b0;
    cyc++;
    if (cen_9) n9++;
    if (psg_cen_48) n48++;
    if (strobes != 8'h00) n_any++;
    if (cen_1008) begin
      if (last_1008 >= 0) per_1008 = cyc - last_1008;
      last_1008 = cyc;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (strobes !== 8'h00) begin n_bad++; $display("FAIL reset_strobes got=%h want=00", strobes); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    n_cmp++; if (slip_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_slip got=%0d want=0", slip_cnt); end
    rst = 1'b1;
    fm_next = cyc;
    tick();
    fm_next = -1;
    n_any = 0;
    repeat (20) tick();
    n_cmp++; if (n_any !== 0) begin n_bad++; $display("FAIL idle_fm_ignored strobes=%0d want=0", n_any); end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_lock();
    int t;
    enable = 1'b1;
    tick();
    n_any = 0;
    t = cyc + 3;
    fm_next = t;
    run_to(t);
    n_cmp++; if (n_any !== 0) begin n_bad++; $display("FAIL seek_quiet strobes=%0d want=0", n_any); end
    run_to(t + 9);
    n_cmp++; if (cen_9 !== 1'b0) begin n_bad++; $display("FAIL first_cen9_early got=%b want=0", cen_9); end
    n9 = 0; n48 = 0;
    tick();
    n_cmp++; if ({cen_9, cen_63, cen_252, cen_1008} !== 4'b1111)
      begin n_bad++; $display("FAIL first_fm_strobes got=%b want=1111", {cen_9, cen_63, cen_252, cen_1008}); end
    run_to(t + 49);
    n_cmp++; if ({psg_cen_48, psg_cen_144, psg_cen_1008, psg_cen_240} !== 4'b1111)
      begin n_bad++; $display("FAIL first_psg_strobes got=%b want=1111",
                              {psg_cen_48, psg_cen_144, psg_cen_1008, psg_cen_240}); end
    run_to(t + 1017);
    n_cmp++; if (n9 !== 112) begin n_bad++; $display("FAIL cen9_per_frame got=%0d want=112", n9); end
    n_cmp++; if (n48 !== 21) begin n_bad++; $display("FAIL psg48_per_frame got=%0d want=21", n48); end
    run_to(t + 4032);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_before got=%b want=0", locked); end
    tick();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after got=%b want=1", locked); end
    n_cmp++; if (per_1008 !== 1008) begin n_bad++; $display("FAIL cen1008_period got=%0d want=1008", per_1008); end
    n_cmp++; if (slip_cnt !== 8'd0) begin n_bad++; $display("FAIL lock_slip got=%0d want=0", slip_cnt); end
    $display("test_lock done at cycle %0d", cyc);
  endtask

  task automatic test_early();
    int e;
    e = fm_next - 500;
    fm_next = e;
    run_to(e + 1);
    n_cmp++; if (slip_cnt !== 8'd1) begin n_bad++; $display("FAIL early_slip got=%0d want=1", slip_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL early_unlock got=%b want=0", locked); end
    run_to(e + 9);
    n_cmp++; if (cen_1008 !== 1'b0) begin n_bad++; $display("FAIL early_resync_pre got=%b want=0", cen_1008); end
    tick();
    n_cmp++; if (cen_1008 !== 1'b1) begin n_bad++; $display("FAIL early_resync_cen1008 got=%b want=1", cen_1008); end
    run_to(e + 4032);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_before got=%b want=0", locked); end
    tick();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock_after got=%b want=1", locked); end
    $display("test_early done at cycle %0d", cyc);
  endtask

  task automatic test_missing();
    int m;
    slip_clr = 1'b1;
    tick();
    slip_clr = 1'b0;
    n_cmp++; if (slip_cnt !== 8'd0) begin n_bad++; $display("FAIL slip_clear got=%0d want=0", slip_cnt); end
    m = fm_next;
    fm_next = m + 1008;
    run_to(m + 1);
    n_cmp++; if (slip_cnt !== 8'd1) begin n_bad++; $display("FAIL missing_slip got=%0d want=1", slip_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL missing_unlock got=%b want=0", locked); end
    run_to(m + 9);
    n9 = 0;
    tick();
    n_cmp++; if (cen_1008 !== 1'b1 || per_1008 !== 1008)
      begin n_bad++; $display("FAIL missing_freerun cen1008=%b period=%0d want=1/1008", cen_1008, per_1008); end
    run_to(m + 1017);
    n_cmp++; if (n9 !== 112) begin n_bad++; $display("FAIL missing_cen9 got=%0d want=112", n9); end
    $display("test_missing done at cycle %0d", cyc);
  endtask

  task automatic test_saturate();
    fm_next = -1;
    slip_clr = 1'b1;
    tick();
    slip_clr = 1'b0;
    fm_force = 1'b1;
    repeat (300) tick();
    n_cmp++; if (slip_cnt !== 8'd255) begin n_bad++; $display("FAIL slip_saturate got=%0d want=255", slip_cnt); end
    slip_clr = 1'b1;
    tick();
    slip_clr = 1'b0;
    fm_force = 1'b0;
    n_cmp++; if (slip_cnt !== 8'd1) begin n_bad++; $display("FAIL slip_clr_with_slip got=%0d want=1", slip_cnt); end
    $display("test_saturate done at cycle %0d", cyc);
  endtask

  task automatic test_disable();
    int f, s;
    f = cyc - 1;
    run_to(f + 19);
    n_cmp++; if (cen_9 !== 1'b1) begin n_bad++; $display("FAIL resume_cen9 got=%b want=1", cen_9); end
    run_to(f + 27);
    enable = 1'b0;
    fm_next = cyc;
    tick();
    fm_next = -1;
    n_cmp++; if (strobes !== 8'h00 || locked !== 1'b0)
      begin n_bad++; $display("FAIL disable_quiet strobes=%h locked=%b want=00/0", strobes, locked); end
    n_cmp++; if (slip_cnt !== 8'd1) begin n_bad++; $display("FAIL disable_fm_ignored slip=%0d want=1", slip_cnt); end
    repeat (3) tick();
    enable = 1'b1;
    n_any = 0;
    repeat (100) tick();
    n_cmp++; if (n_any !== 0) begin n_bad++; $display("FAIL reenable_seek strobes=%0d want=0", n_any); end
    s = cyc;
    fm_next = s;
    run_to(s + 9);
    n_cmp++; if (cen_9 !== 1'b0) begin n_bad++; $display("FAIL reseek_pre got=%b want=0", cen_9); end
    tick();
    n_cmp++; if (cen_9 !== 1'b1) begin n_bad++; $display("FAIL reseek_cen9 got=%b want=1", cen_9); end
    run_to(s + 97);
    n_cmp++; if (psg_cen_48 !== 1'b1 || psg_cen_240 !== 1'b0)
      begin n_bad++; $display("FAIL psg_second got=%b%b want=10", psg_cen_48, psg_cen_240); end
    $display("test_disable done at cycle %0d", cyc);
  endtask

  task automatic test_async_reset();
    int r;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (strobes !== 8'h00 || locked !== 1'b0)
      begin n_bad++; $display("FAIL async_rst_strobes got=%h/%b want=00/0", strobes, locked); end
    n_cmp++; if (slip_cnt !== 8'd0) begin n_bad++; $display("FAIL async_rst_slip got=%0d want=0", slip_cnt); end
    rst = 1'b1;
    fm_next = -1;
    tick();
    r = cyc + 2;
    fm_next = r;
    run_to(r + 49);
    n_cmp++; if (psg_cen_240 !== 1'b1) begin n_bad++; $display("FAIL psg240_first got=%b want=1", psg_cen_240); end
    run_to(r + 97);
    n_cmp++; if (psg_cen_240 !== 1'b0) begin n_bad++; $display("FAIL psg240_gap got=%b want=0", psg_cen_240); end
    run_to(r + 289);
    n_cmp++; if (psg_cen_240 !== 1'b1) begin n_bad++; $display("FAIL psg240_period got=%b want=1", psg_cen_240); end
    $display("test_async_reset done at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_early();
    test_missing();
    test_saturate();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d want=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jt12_mixsched.md
# jt12_mixsched

Clock-enable scheduler for the Megadrive/Genesis output mixer. It produces every FM and PSG rate strobe the mixer's interpolation/decimation chains consume, all derived from one 1008-cycle frame counter. It phase-locks that frame to the FM chip's sample-ready pulse, so mixer sample boundaries line up with real FM output samples. It reports lock status and a slip count for debug.

## Interface
Parameters:
- LOCK_N, 4: consecutive good frames required before `locked` asserts (1..15).
- FRAME, 1008: clk cycles per FM sample. Must be divisible by 9, 63, 252, 48 and 144.

Ports:
- clk  in  1  system clock (54 MHz nominal).
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  scheduler run request; level-sensitive.
- fm_sample  in  1  one-cycle pulse from the FM core per output sample.
- slip_clr  in  1  synchronous clear of `slip_cnt`.
- cen_9, cen_63, cen_252, cen_1008  out  1 each  FM uprate strobes.
- psg_cen_48, psg_cen_144, psg_cen_240, psg_cen_1008  out  1 each  PSG chain strobes.
- locked  out  1  frame aligned to `fm_sample`.
- slip_cnt  out  8  saturating count of alignment errors.

## Operation
- Frame counter p runs 0..FRAME-1 and wraps. psg5 is a free-running mod-5 counter that advances when p mod 48 == 47.
- All strobes are registered: each is high exactly one cycle, on the cycle after the condition holds.
  - cen_9: p mod 9 == 8.
  - cen_63: p mod 63 == 8.
  - cen_252: p mod 252 == 8.
  - cen_1008: p == 8.
  - psg_cen_48: p mod 48 == 47.
  - psg_cen_144: p mod 144 == 47.
  - psg_cen_1008: p == 47.
  - psg_cen_240: p mod 48 == 47 and psg5 == 0.
- psg_cen_240 is not frame-periodic, because 1008 is not a multiple of 240. psg5 is reset only by rst and by entry to SEEK.
- FSM states:
  - IDLE: p = 0, psg5 = 0, all strobes 0, locked = 0. Moves to SEEK when enable = 1.
  - SEEK: p and psg5 held at 0, strobes 0. Moves to RUN on fm_sample, and p = 0 on the next cycle.
  - RUN: p counts and strobes are generated. Frame check:
    - Good frame: fm_sample while p == FRAME-1. Increments the good count, saturating at LOCK_N. locked = 1 once the good count reaches LOCK_N.
    - Early pulse: fm_sample with p != FRAME-1. Counts as a slip. Next p = 0 (resync). Strobes for the aborted frame tail are dropped.
    - Missing pulse: p == FRAME-1 without fm_sample. Counts as a slip. p wraps normally (free-run).
  - Any slip: good count = 0, locked = 0 next cycle, slip_cnt increments (saturates at 255).
  - enable = 0 in any state: IDLE on the next cycle. All strobes and locked go low that same next cycle.
- slip_clr together with a slip in the same cycle: slip_cnt = 1.

## Timing
- Reset: all outputs 0, slip_cnt = 0, state IDLE, p = 0, psg5 = 0, good count = 0.
- fm_sample in SEEK at cycle t:
  - p = 0 at t+1.
  - First cen_9 at t+10.
  - First cen_1008 at t+10.
  - First psg_cen_48 at t+49.
- Strobe spacing in steady RUN:
  - cen_9 every 9 cycles.
  - cen_63 every 63 cycles.
  - cen_252 every 252 cycles.
  - cen_1008 every 1008 cycles.
  - psg_cen_48 every 48 cycles.
  - psg_cen_144 every 144 cycles.
  - psg_cen_1008 every 1008 cycles.
  - psg_cen_240 every 240 cycles.
- Coincidence: cen_1008 coincides with cen_252, cen_63 and cen_9; psg_cen_1008 coincides with psg_cen_144 and psg_cen_48.
- locked rises 1 cycle after the LOCK_N-th good fm_sample. slip_cnt updates 1 cycle after the detecting edge.
- fm_sample in IDLE is ignored. fm_sample on the same cycle enable falls is ignored.

## Structure
- Package jt12_mix_pkg holds:
  - FSM state typedef (IDLE, SEEK, RUN).
  - Divider constants 9, 63, 252, 48, 144, 5.
  - Strobe-phase constants 8 and 47.
- Sub-module jt12_mixsched_div: mod-N counter with clear, enable and a registered wrap strobe. Instantiate it for the p-derived moduli and for psg5.
- Top level holds the FSM, lock/slip logic and strobe registers.

## Test plan
- Reset, then enable with fm_sample every 1008 cycles:
  - locked rises 1 cycle after the 4th good pulse.
  - cen_1008 period is 1008.
  - 112 cen_9 per frame, 21 psg_cen_48 per frame.
  - slip_cnt = 0.
- Locked, then fm_sample arrives 500 cycles early:
  - slip_cnt = 1 and locked = 0.
  - p restarts, and next cen_1008 comes 10 cycles after that pulse.
  - Relock after 4 good frames.
- Locked, then one fm_sample is suppressed:
  - slip_cnt = 1 and locked drops.
  - Strobes continue uninterrupted.
- 300 slips:
  - slip_cnt saturates at 255.
  - slip_clr on the same cycle as a slip gives 1.
- enable dropped mid-frame:
  - All strobes 0 from the next cycle.
  - Re-enable waits in SEEK; no strobes until fm_sample.
- rst asserted mid-RUN, asynchronously between edges:
  - Outputs 0 immediately.
  - psg_cen_240 phase restarts with psg5 = 0.
